// File: rtl/mpi_tick_sequencer.sv
// Run controller for the MPI-partitioned simulation top: sequences the DUT reset
// window, init/run work ticks, acknowledge pacing and finalize on completion or fault.
module mpi_tick_sequencer #(
   parameter int unsigned RESET_TICKS    = 5,
   parameter int unsigned RUN_TICKS      = 20,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             valid_i,
   input  logic [31:0]      rank_i,
   output logic             dut_rstn_o,
   output logic             mpi_work_o,
   output logic             finalize_o,
   output logic [CNT_W-1:0] tick_cnt_o,
   output logic [31:0]      rank_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             error_o
);
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT_PULSE,
      S_INIT_GAP,
      S_RELEASE,
      S_RUN_PULSE,
      S_RUN_WAIT,
      S_FINALIZE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] init_cnt, init_cnt_n;
   logic [CNT_W-1:0] tick_cnt_n;
   logic [TO_W-1:0]  to_cnt, to_cnt_n;
   logic             rank_vld, rank_vld_n;
   logic [31:0]      rank_n;

   always_comb begin
      state_n    = state;
      init_cnt_n = init_cnt;
      tick_cnt_n = tick_cnt_o;
      to_cnt_n   = to_cnt;
      rank_vld_n = rank_vld;
      rank_n     = rank_o;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_i) begin
               state_n    = S_INIT_PULSE;
               init_cnt_n = '0;
               tick_cnt_n = '0;
               to_cnt_n   = '0;
               rank_vld_n = 1'b0;
            end
         end
         S_INIT_PULSE: state_n = S_INIT_GAP;
         S_INIT_GAP: begin
            init_cnt_n = init_cnt + CNT_W'(1);
            state_n    = (init_cnt_n == CNT_W'(RESET_TICKS)) ? S_RELEASE : S_INIT_PULSE;
         end
         S_RELEASE: state_n = S_RUN_PULSE;
         S_RUN_PULSE: begin
            to_cnt_n = '0;
            state_n  = S_RUN_WAIT;
         end
         S_RUN_WAIT: begin
            if (valid_i) begin
               tick_cnt_n = tick_cnt_o + CNT_W'(1);
               if (!rank_vld) begin
                  rank_n     = rank_i;
                  rank_vld_n = 1'b1;
               end
               // A rank change after the first acknowledge is a fault, even on the last tick.
               if (rank_vld && (rank_i != rank_o)) begin
                  state_n = S_ERROR;
               end else if (tick_cnt_n == CNT_W'(RUN_TICKS)) begin
                  state_n = S_FINALIZE;
               end else begin
                  state_n = S_RUN_PULSE;
               end
            end else begin
               to_cnt_n = to_cnt + TO_W'(1);
               if (to_cnt_n == TO_W'(TIMEOUT_CYCLES)) begin
                  state_n = S_ERROR;
               end
            end
         end
         S_FINALIZE: state_n = S_DONE;
         default:    state_n = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each lines up with the state it describes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         init_cnt   <= '0;
         to_cnt     <= '0;
         rank_vld   <= 1'b0;
         tick_cnt_o <= '0;
         rank_o     <= '0;
         dut_rstn_o <= 1'b0;
         mpi_work_o <= 1'b0;
         finalize_o <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         error_o    <= 1'b0;
      end else begin
         state      <= state_n;
         init_cnt   <= init_cnt_n;
         to_cnt     <= to_cnt_n;
         rank_vld   <= rank_vld_n;
         tick_cnt_o <= tick_cnt_n;
         rank_o     <= rank_n;
         dut_rstn_o <= state_n inside {S_RELEASE, S_RUN_PULSE, S_RUN_WAIT,
                                       S_FINALIZE, S_DONE, S_ERROR};
         mpi_work_o <= state_n inside {S_INIT_PULSE, S_RUN_PULSE};
         finalize_o <= state_n inside {S_FINALIZE, S_DONE, S_ERROR};
         busy_o     <= !(state_n inside {S_IDLE, S_DONE, S_ERROR});
         done_o     <= (state_n == S_DONE);
         error_o    <= (state_n == S_ERROR);
      end
   end

endmodule

// File: tb/tb_mpi_tick_sequencer.sv
// Scoreboard bench for mpi_tick_sequencer: planned sequences push expected events,
// a negedge monitor pops and compares whenever the DUT shows one.
module tb_mpi_tick_sequencer;
   localparam int R = 5;
   localparam int N = 20;
   localparam int T = 8;
   localparam int EV_WORK = 0;
   localparam int EV_RSTN = 1;
   localparam int EV_FIN  = 2;
   localparam int EV_TERM = 3;

   typedef struct {
      int          kind;
      longint      cyc;
      logic        rstn;
      logic        done;
      logic        err;
      int          cnt;
      logic [31:0] rank;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [31:0] rank_i = '0;
   logic        dut_rstn_o, mpi_work_o, finalize_o, busy_o, done_o, error_o;
   logic [15:0] tick_cnt_o;
   logic [31:0] rank_o;

   longint      cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;
   ev_t         sb[$];
   int          d[1:N];
   logic [31:0] rk[1:N];
   logic [31:0] model_rank = '0;
   logic        p_rstn = 1'b0, p_fin = 1'b0, p_done = 1'b0, p_err = 1'b0;

   mpi_tick_sequencer #(
      .RESET_TICKS(R),
      .RUN_TICKS(N),
      .TIMEOUT_CYCLES(T),
      .CNT_W(16)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .start_i(start_i),
      .valid_i(valid_i),
      .rank_i(rank_i),
      .dut_rstn_o(dut_rstn_o),
      .mpi_work_o(mpi_work_o),
      .finalize_o(finalize_o),
      .tick_cnt_o(tick_cnt_o),
      .rank_o(rank_o),
      .busy_o(busy_o),
      .done_o(done_o),
      .error_o(error_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_dut_rstn"}, dut_rstn_o, 0);
      chk({tag, "_mpi_work"}, mpi_work_o, 0);
      chk({tag, "_finalize"}, finalize_o, 0);
      chk({tag, "_tick_cnt"}, tick_cnt_o, 0);
      chk({tag, "_rank"}, rank_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_error"}, error_o, 0);
   endtask

   function automatic void push(input int kind, input longint c, input logic rstn,
                                input logic dn, input logic er, input int cnt);
      ev_t e;
      e.kind = kind; e.cyc = c; e.rstn = rstn; e.done = dn; e.err = er;
      e.cnt = cnt; e.rank = model_rank;
      sb.push_back(e);
   endfunction

   task automatic take(input int kind);
      ev_t e;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
      end else begin
         e = sb.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_cycle", cyc, e.cyc);
         if (kind == e.kind) begin
            if (kind == EV_WORK) begin
               chk("work_dut_rstn", dut_rstn_o, e.rstn);
               chk("work_busy", busy_o, 1);
            end else if (kind == EV_TERM) begin
               chk("term_done", done_o, e.done);
               chk("term_error", error_o, e.err);
               chk("term_finalize", finalize_o, 1);
               chk("term_tick_cnt", tick_cnt_o, e.cnt);
               chk("term_rank", rank_o, e.rank);
               chk("term_busy", busy_o, 0);
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_i) begin
            if (mpi_work_o) take(EV_WORK);
            if (dut_rstn_o && !p_rstn) take(EV_RSTN);
            if (finalize_o && !p_fin) take(EV_FIN);
            if ((done_o && !p_done) || (error_o && !p_err)) take(EV_TERM);
         end
         p_rstn = dut_rstn_o;
         p_fin  = finalize_o;
         p_done = done_o;
         p_err  = error_o;
      end
   end

   function automatic logic noise_bit(input int mode);
      if (mode == 2) return 1'b1;
      if (mode == 1) return 1'($urandom_range(0, 1));
      return 1'b0;
   endfunction

   // Plans one sequence from d[]/rk[] (d==0: never acknowledged), pushes its
   // expected events, then drives start, acknowledges and noise cycle by cycle.
   task automatic run_seq(input int abort_tick, input int noise);
      bit          is_wait[int];
      logic [31:0] ack_rank[int];
      longint      base;
      int          t, cnt, last_c, abort_c, end_c, sn;
      bit          rv;
      @(negedge clk);
      base    = cyc;
      start_i = 1'b1;
      valid_i = noise_bit(noise);
      rank_i  = $urandom;
      rv = 0; cnt = 0; last_c = 0; abort_c = -1;
      for (int i = 0; i < R; i++) push(EV_WORK, base + 2 * i + 1, 1'b0, 1'b0, 1'b0, 0);
      push(EV_RSTN, base + 2 * R + 1, 1'b1, 1'b0, 1'b0, 0);
      t = 2 * R + 2;
      for (int k = 1; k <= N; k++) begin
         push(EV_WORK, base + t, 1'b1, 1'b0, 1'b0, 0);
         if (k == abort_tick) begin
            abort_c = t;
            break;
         end
         if (d[k] == 0) begin
            for (int w = 1; w <= T; w++) is_wait[t + w] = 1'b1;
            last_c = t + T + 1;
            push(EV_FIN, base + last_c, 1'b1, 1'b0, 1'b0, 0);
            push(EV_TERM, base + last_c, 1'b1, 1'b0, 1'b1, cnt);
            break;
         end
         for (int w = 1; w < d[k]; w++) is_wait[t + w] = 1'b1;
         ack_rank[t + d[k]] = rk[k];
         cnt++;
         if (!rv) begin
            rv = 1;
            model_rank = rk[k];
         end else if (rk[k] != model_rank) begin
            last_c = t + d[k] + 1;
            push(EV_FIN, base + last_c, 1'b1, 1'b0, 1'b0, 0);
            push(EV_TERM, base + last_c, 1'b1, 1'b0, 1'b1, cnt);
            break;
         end
         if (k == N) begin
            push(EV_FIN, base + t + d[k] + 1, 1'b1, 1'b0, 1'b0, 0);
            last_c = t + d[k] + 2;
            push(EV_TERM, base + last_c, 1'b1, 1'b1, 1'b0, cnt);
            break;
         end
         t = t + d[k] + 1;
      end
      sn    = $urandom_range(1, 2 * R + 1);
      end_c = (abort_c >= 0) ? abort_c : last_c + $urandom_range(0, 2);
      for (int c = 1; c <= end_c; c++) begin
         @(negedge clk);
         start_i = (c == sn);
         if (ack_rank.exists(c)) begin
            valid_i = 1'b1;
            rank_i  = ack_rank[c];
         end else if (is_wait.exists(c)) begin
            valid_i = 1'b0;
            rank_i  = $urandom;
         end else begin
            valid_i = noise_bit(noise);
            rank_i  = $urandom;
         end
      end
      if (abort_c >= 0) begin
         #2 rst_i = 1'b1;
         #1 chk_reset("abort");
         sb.delete();
         model_rank = '0;
         @(negedge clk);
         rst_i   = 1'b0;
         valid_i = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] seq_rank;
      int          bad;
      @(negedge clk);
      chk_reset("reset");
      rst_i = 1'b0;

      for (int k = 1; k <= N; k++) begin d[k] = 1; rk[k] = 32'd3; end
      run_seq(0, 0);

      for (int k = 1; k <= N; k++) begin d[k] = $urandom_range(1, T); rk[k] = 32'd3; end
      rk[7] = 32'd4;
      run_seq(0, 1);

      for (int k = 1; k <= N; k++) begin d[k] = 1; rk[k] = 32'd3; end
      d[2] = 0;
      run_seq(0, 0);

      for (int k = 1; k <= N; k++) begin d[k] = $urandom_range(1, T); rk[k] = 32'd3; end
      d[2] = T;
      run_seq(0, 0);

      for (int k = 1; k <= N; k++) begin d[k] = $urandom_range(1, T); rk[k] = 32'd9; end
      run_seq(0, 2);

      for (int k = 1; k <= N; k++) begin d[k] = $urandom_range(1, 3); rk[k] = 32'd3; end
      run_seq(10, 1);
      for (int k = 1; k <= N; k++) begin d[k] = 1; rk[k] = 32'd3; end
      run_seq(0, 2);

      for (int s = 0; s < 8; s++) begin
         seq_rank = $urandom;
         bad = ($urandom_range(0, 3) == 0) ? $urandom_range(2, N) : 0;
         for (int k = 1; k <= N; k++) begin
            d[k]  = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, T);
            rk[k] = (k == bad) ? (seq_rank ^ 32'h1) : seq_rank;
         end
         run_seq(0, $urandom_range(0, 2));
      end

      repeat (6) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mpi_tick_sequencer.md
# mpi_tick_sequencer

Upstream run controller for the MPI-partitioned simulation top (`top_mpi_tb`); it replaces hand-written testbench sequencing.
- Generates the DUT's active-low reset window and the `mpi_work` tick pulses for both the init phase and the run phase.
- Paces each run tick on the DUT's `valid_o` acknowledge and latches the reported rank.
- Raises `finalize` after a programmed tick count, or on a fault.

## Interface
- RESET_TICKS, 5: number of work pulses issued while DUT reset is held; legal range 1..2^CNT_W-1.
- RUN_TICKS, 20: number of acknowledged run ticks before finalize; legal range 1..2^CNT_W-1.
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for an acknowledge; legal range ≥1.
- CNT_W, 16: width of the tick counters and `tick_cnt_o`.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle request to start a sequence; honoured only in IDLE, DONE or ERROR.
- valid_i  in  1  tick acknowledge, driven from the DUT `valid_o`.
- rank_i  in  32  MPI rank reported by the DUT, qualified by `valid_i`.
- dut_rstn_o  out  1  active-low reset to the DUT.
- mpi_work_o  out  1  one-cycle work pulse, one per tick.
- finalize_o  out  1  finalize request to the DUT.
- tick_cnt_o  out  CNT_W  count of acknowledged run ticks.
- rank_o  out  32  rank latched on the first run acknowledge.
- busy_o  out  1  high in every state except IDLE, DONE and ERROR.
- done_o  out  1  high in DONE.
- error_o  out  1  high in ERROR; sticky.

## Operation
- All outputs are registered.
- Reset values: `dut_rstn_o`=0, `mpi_work_o`=0, `finalize_o`=0, `tick_cnt_o`=0, `rank_o`=0, `busy_o`=0, `done_o`=0, `error_o`=0. State resets to IDLE.
- IDLE: `dut_rstn_o`=0. `start_i` moves to INIT_PULSE and clears the init counter, `tick_cnt_o`, the rank-valid flag and the timeout counter.
- INIT_PULSE: `mpi_work_o`=1 for one cycle, then INIT_GAP.
- INIT_GAP: `mpi_work_o`=0 and the init counter increments.
  - If the counter reaches RESET_TICKS, go to RELEASE.
  - Otherwise return to INIT_PULSE.
- RELEASE: `dut_rstn_o` goes 1 and stays 1 until the next IDLE or start. Hold for one settle cycle, then go to RUN_PULSE.
- RUN_PULSE: `mpi_work_o`=1 for one cycle, clear the timeout counter, then go to RUN_WAIT.
- RUN_WAIT: `mpi_work_o`=0. Sample `valid_i` each cycle.
  - On `valid_i`=1:
    - Increment `tick_cnt_o`.
    - If the rank-valid flag is clear, latch `rank_i` into `rank_o` and set the flag.
    - If the flag is set and `rank_i`≠`rank_o`, go to ERROR.
    - Otherwise, if `tick_cnt_o`+1 equals RUN_TICKS, go to FINALIZE.
    - Otherwise go to RUN_PULSE.
  - On `valid_i`=0: increment the timeout counter. When it reaches TIMEOUT_CYCLES, go to ERROR.
- FINALIZE: `finalize_o`=1 for one cycle, then DONE.
- DONE: `finalize_o` stays 1 and `done_o`=1. `start_i` restarts the sequence at INIT_PULSE: it drops `finalize_o` and `done_o`, drives `dut_rstn_o`=0, and clears the counters.
- ERROR: `error_o`=1 and `finalize_o`=1, so the MPI ranks shut down cleanly; `done_o`=0. Only `start_i` or `rst_i` leaves ERROR.
- Boundary rules:
  - `valid_i` is ignored outside RUN_WAIT, including during the RUN_PULSE cycle itself.
  - `start_i` is ignored while `busy_o`=1.
  - An asserted `rst_i` immediately forces all outputs to their reset values, whatever the state. This includes `dut_rstn_o`=0 and `finalize_o`=0.
  - `tick_cnt_o` never wraps, because RUN_TICKS must fit in CNT_W.

## Timing
- `start_i` sampled at cycle 0 gives the first `mpi_work_o` pulse at cycle 1.
- The init phase takes 2×RESET_TICKS cycles. `dut_rstn_o` rises at cycle 2×RESET_TICKS+1.
- The first run pulse occurs at cycle 2×RESET_TICKS+2.
- Minimum run-tick period is 2 cycles (pulse, then `valid_i` in the first RUN_WAIT cycle).
- `finalize_o` rises on the cycle after the last acknowledge.
- Timeout boundary, counting RUN_WAIT cycles without an acknowledge:
  - ERROR is entered on the cycle after the TIMEOUT_CYCLES-th such cycle.
  - An acknowledge in exactly that TIMEOUT_CYCLES-th cycle is accepted and wins over the timeout.

## Test plan
- Defaults, `valid_i` tied to a 1-cycle-delayed `mpi_work_o` -> 5 pulses with `dut_rstn_o`=0. `dut_rstn_o` rises at cycle 11. 20 run pulses follow. `tick_cnt_o`=20, then `finalize_o`=1 and `done_o`=1. `error_o` stays 0.
- `rank_i`=3 on every acknowledge -> `rank_o`=3 after the first run acknowledge and unchanged afterwards.
- `rank_i` changes from 3 to 4 at tick 7 -> ERROR entered. `error_o`=1, `finalize_o`=1, `tick_cnt_o`=7.
- TIMEOUT_CYCLES=8 with no acknowledge at tick 2 -> `error_o` rises exactly 9 cycles after that run pulse. An acknowledge in wait cycle 8 instead gives no error.
- `valid_i` held at 1 during init, RELEASE and the RUN_PULSE cycles -> `tick_cnt_o` increments only in RUN_WAIT. The total is still exactly RUN_TICKS.
- `rst_i` asserted mid-run at tick 10, then `start_i` -> all outputs return to their reset values asynchronously. The full sequence then replays from tick 0. `start_i` pulsed while `busy_o`=1 has no effect.
